// File: rtl/wb_sram_arbiter_pkg.sv
// Shared types and constants for the WISHBONE SRAM arbiter.
package wb_sram_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_TO_W = 8;

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational winner picker: round-robin from ptr, or lowest index when fixed is set.
module wb_arb_rr_picker #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             fixed,
  output logic [NUM_M-1:0] onehot,
  output logic [IW-1:0]    index
);

  int unsigned c;
  logic        found;

  // Scan NUM_M candidates starting at ptr (or 0), wrapping at NUM_M-1.
  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    c      = 0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      c = fixed ? i : 32'(ptr) + i;
      if (c >= NUM_M) c = c - NUM_M;
      if (!found && req[c]) begin
        found     = 1'b1;
        onehot[c] = 1'b1;
        index     = IW'(c);
      end
    end
  end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Shares one WISHBONE SRAM slave between NUM_M initiators; ownership held for a whole cyc.
// Optional stall watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_sram_arbiter
  import wb_sram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M       = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned FIXED_PRIO  = 0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*AW-1:0]   m_adr_i,
  input  logic [NUM_M*DW/8-1:0] m_sel_i,
  input  logic [NUM_M*DW-1:0]   m_dat_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic [DW-1:0]         s_dat_o,
  input  logic [DW-1:0]         s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  output logic [NUM_M-1:0]      gnt_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  if (NUM_M < 2 || NUM_M > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << ARB_TO_W)) begin : g_cfg_err
    $error("wb_sram_arbiter: parameter out of range");
  end

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d, pick_onehot;
  logic [IW-1:0]    own_q, own_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic             own_cyc;
  logic             to_err;

  assign own_cyc = |(m_cyc_i & gnt_q);
  assign gnt_o   = gnt_q;
  assign m_dat_o = s_dat_i;

  wb_arb_rr_picker #(
    .NUM_M (NUM_M),
    .IW    (IW)
  ) u_picker (
    .req    (m_cyc_i),
    .ptr    (rr_ptr_q),
    .fixed  (FIXED_PRIO != 0),
    .onehot (pick_onehot),
    .index  (pick_idx)
  );

  // Ownership FSM; the return to IDLE forces one dead cycle between owners.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    own_d    = own_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ARB_BUSY;
          gnt_d   = pick_onehot;
          own_d   = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!own_cyc) begin
          state_d  = ARB_IDLE;
          gnt_d    = '0;
          rr_ptr_d = (own_q == IW'(NUM_M - 1)) ? '0 : own_q + IW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      own_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      own_q    <= own_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Owner's bus steered to the slave; replies returned only to the owner.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_q[k]) begin
        s_cyc_o    = m_cyc_i[k];
        s_stb_o    = m_stb_i[k] & ~to_err;
        s_we_o     = m_we_i[k];
        s_adr_o    = m_adr_i[k*AW +: AW];
        s_sel_o    = m_sel_i[k*SW +: SW];
        s_dat_o    = m_dat_i[k*DW +: DW];
        m_ack_o[k] = s_ack_i;
        m_err_o[k] = s_err_i | to_err;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [ARB_TO_W-1:0] to_cnt_q;
  logic                to_err_q;
  logic                counting;
  logic                to_hit;

  assign counting = (state_q == ARB_BUSY) && s_stb_o && !s_ack_i && !s_err_i;
  assign to_hit   = counting && (to_cnt_q == ARB_TO_W'(TIMEOUT_CYC));
  assign to_err   = to_err_q;

  // Limit reached: next cycle errors the owner with stb suppressed, unless it is leaving.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= to_hit && own_cyc;
      if (counting && !to_hit) to_cnt_q <= to_cnt_q + ARB_TO_W'(1);
      else                     to_cnt_q <= '0;
    end
  end
`else
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed bench for wb_sram_arbiter: reset, single read/write, round-robin, burst hold,
// fixed priority (second instance) and stall/watchdog behaviour.
module tb_wb_sram_arbiter;

  localparam int unsigned NUM_M = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 16;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_M-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NUM_M*AW-1:0]   m_adr_i;
  logic [NUM_M*DW/8-1:0] m_sel_i;
  logic [NUM_M*DW-1:0]   m_dat_i;
  logic [DW-1:0]         s_dat_i;
  logic                  s_ack_i, s_err_i;

  logic [DW-1:0]         m_dat_o, s_dat_o, f_m_dat_o, f_s_dat_o;
  logic [NUM_M-1:0]      m_ack_o, m_err_o, gnt_o, f_m_ack_o, f_m_err_o, f_gnt_o;
  logic                  s_cyc_o, s_stb_o, s_we_o, f_s_cyc_o, f_s_stb_o, f_s_we_o;
  logic [AW-1:0]         s_adr_o, f_s_adr_o;
  logic [DW/8-1:0]       s_sel_o, f_s_sel_o;

  always #5 clk = ~clk;

  wb_sram_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .FIXED_PRIO(0), .TIMEOUT_CYC(TO_CYC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  wb_sram_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .FIXED_PRIO(1), .TIMEOUT_CYC(TO_CYC)) dut_fp (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_dat_o(f_m_dat_o), .m_ack_o(f_m_ack_o),
    .m_err_o(f_m_err_o), .s_cyc_o(f_s_cyc_o), .s_stb_o(f_s_stb_o), .s_we_o(f_s_we_o),
    .s_adr_o(f_s_adr_o), .s_sel_o(f_s_sel_o), .s_dat_o(f_s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(f_gnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic int idx(input logic [NUM_M-1:0] g);
    for (int i = 0; i < NUM_M; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Simple initiator/slave model state for the autonomous phases.
  bit               use_fp;
  int               rem [NUM_M];
  int               blen[NUM_M];
  int               beats[NUM_M];
  int               fall_cyc[NUM_M];
  int               glog[$];
  int               gcyc[$];
  int               gaps[$];
  logic [NUM_M-1:0] alog[$];

  task automatic run_auto(input string tag, input int max_cyc);
    logic [NUM_M-1:0] cyc_nx, g, pg, ack;
    logic             stb, ack_nx;
    int               zr, left;
    bit               done;
    cyc_nx = m_cyc_i; ack_nx = 1'b0; pg = '0; zr = 0; done = 0;
    glog.delete(); gcyc.delete(); gaps.delete(); alog.delete();
    for (int n = 0; n < max_cyc && !done; n++) begin
      next();
      for (int k = 0; k < NUM_M; k++) if (m_cyc_i[k] && !cyc_nx[k]) fall_cyc[k] = n;
      m_cyc_i = cyc_nx; m_stb_i = cyc_nx; s_ack_i = ack_nx; s_dat_i = 32'(n);
      mid();
      g   = use_fp ? f_gnt_o   : gnt_o;
      ack = use_fp ? f_m_ack_o : m_ack_o;
      stb = use_fp ? f_s_stb_o : s_stb_o;
      if (g == '0) zr++;
      else begin
        if (g != pg) begin glog.push_back(idx(g)); gcyc.push_back(n); gaps.push_back(zr); end
        zr = 0;
      end
      pg = g;
      if (ack != '0) alog.push_back(g);
      left = 0;
      for (int k = 0; k < NUM_M; k++) begin
        if (m_cyc_i[k]) begin
          if (ack[k]) begin
            beats[k]--;
            if (beats[k] == 0) begin rem[k]--; cyc_nx[k] = 1'b0; end
          end
        end else if (rem[k] > 0) begin
          cyc_nx[k] = 1'b1;
          beats[k]  = blen[k];
        end
        left += rem[k];
      end
      ack_nx = stb && !s_ack_i;
      done = (left == 0) && (m_cyc_i == '0) && (g == '0);
    end
    check({tag, "_completed"}, 64'(done), 64'd1);
  endtask

  int s_cyc_first, e_count, e_cyc;
  logic e_stb;
  logic [NUM_M-1:0] e_val;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; m_cyc_i = 4'hf; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_sel_i = '0;
    m_dat_i = '0; s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; use_fp = 0;
    for (int k = 0; k < NUM_M; k++) begin rem[k] = 0; blen[k] = 1; beats[k] = 0; fall_cyc[k] = 0; end

    // Reset with all initiators requesting
    mid();
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    check("rst_ack", 64'(m_ack_o), 64'h0);
    next(); rst = 1'b0;
    mid();
    check("rst_last_gnt", 64'(gnt_o), 64'h0);
    next(); mid();
    check("first_gnt", 64'(gnt_o), 64'h1);
    next(); m_cyc_i = '0;
    next(); mid();
    check("idle_after_m0", 64'(gnt_o), 64'h0);

    // Single read by m1, slave acks on the 4th stb cycle
    next();
    m_adr_i[0*AW +: AW] = 32'h0000_0111; m_adr_i[2*AW +: AW] = 32'h0000_0222;
    m_adr_i[1*AW +: AW] = 32'h0000_0040; m_sel_i[1*4 +: 4] = 4'hf;
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
    mid();
    check("rd_no_gnt_yet", 64'(gnt_o), 64'h0);
    next(); mid();
    check("rd_gnt", 64'(gnt_o), 64'h2);
    check("rd_s_cyc", 64'(s_cyc_o), 64'h1);
    check("rd_s_stb", 64'(s_stb_o), 64'h1);
    check("rd_s_adr", 64'(s_adr_o), 64'h40);
    check("rd_s_we", 64'(s_we_o), 64'h0);
    next(); mid();
    check("rd_wait_ack", 64'(m_ack_o), 64'h0);
    next();
    next(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    mid();
    check("rd_ack", 64'(m_ack_o), 64'h2);
    check("rd_dat", 64'(m_dat_o), 64'hDEAD_BEEF);
    next(); s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    mid();
    check("rd_ack_single", 64'(m_ack_o), 64'h0);
    check("rd_gnt_held", 64'(gnt_o), 64'h2);
    next(); s_ack_i = 1'b1;
    mid();
    check("rd_idle_gnt", 64'(gnt_o), 64'h0);
    check("ack_idle_ignored", 64'(m_ack_o), 64'h0);

    // Write by m2 with cyc dropped in the ack cycle
    next(); s_ack_i = 1'b0;
    m_adr_i[2*AW +: AW] = 32'h0000_0080; m_sel_i[2*4 +: 4] = 4'b0011;
    m_dat_i[2*DW +: DW] = 32'h1234_5678; m_dat_i[1*DW +: DW] = 32'hAAAA_5555;
    m_we_i = 4'b0100; m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    next(); mid();
    check("wr_s_we", 64'(s_we_o), 64'h1);
    check("wr_s_dat", 64'(s_dat_o), 64'h1234_5678);
    check("wr_s_sel", 64'(s_sel_o), 64'h3);
    check("wr_s_adr", 64'(s_adr_o), 64'h80);
    next(); s_ack_i = 1'b1; m_cyc_i = '0; m_stb_i = '0;
    mid();
    check("wr_ack_with_cyc_drop", 64'(m_ack_o), 64'h4);
    next(); s_ack_i = 1'b0; m_we_i = '0;
    mid();
    check("wr_idle_gnt", 64'(gnt_o), 64'h0);

    // Round-robin: m0..m2 four single transfers each
    rem[0] = 4; rem[1] = 4; rem[2] = 4;
    run_auto("rr", 300);
    check("rr_grant_count", 64'(glog.size()), 64'd12);
    for (int i = 0; i < 12; i++) check($sformatf("rr_order_%0d", i), 64'(glog[i]), 64'(i % 3));
    for (int i = 1; i < 12; i++) check($sformatf("rr_gap_%0d", i), 64'(gaps[i]), 64'd1);

    // Burst hold: m3 eight beats while m0 waits
    rem[3] = 1; blen[3] = 8; rem[0] = 1; blen[0] = 1;
    run_auto("burst", 300);
    check("burst_grant_count", 64'(glog.size()), 64'd2);
    check("burst_first_owner", 64'(glog[0]), 64'd3);
    check("burst_ack_count", 64'(alog.size()), 64'd9);
    for (int i = 0; i < 8; i++) check($sformatf("burst_gnt_beat_%0d", i), 64'(alog[i]), 64'h8);
    check("burst_next_owner", 64'(glog[1]), 64'd0);
    check("burst_handover_edges", 64'(gcyc[1] - fall_cyc[3]), 64'd2);

    // Fixed priority instance: m0 and m2 request continuously
    use_fp = 1; blen[3] = 1;
    rem[0] = 3; rem[2] = 2;
    run_auto("fp", 300);
    check("fp_grant_count", 64'(glog.size()), 64'd5);
    check("fp_order_0", 64'(glog[0]), 64'd0);
    check("fp_order_1", 64'(glog[1]), 64'd0);
    check("fp_order_2", 64'(glog[2]), 64'd0);
    check("fp_order_3", 64'(glog[3]), 64'd2);
    check("fp_order_4", 64'(glog[4]), 64'd2);
    use_fp = 0;

    // Stalled slave: m1 request never acked
    next(); m_cyc_i = 4'b0010; m_stb_i = 4'b0010; s_ack_i = 1'b0;
    s_cyc_first = -1; e_count = 0; e_cyc = -1; e_stb = 1'b1; e_val = '0;
    for (int n = 0; n < 30; n++) begin
      mid();
      if (s_cyc_first < 0 && s_stb_o) s_cyc_first = n;
      if (m_err_o != '0) begin e_count++; e_cyc = n; e_stb = s_stb_o; e_val = m_err_o; end
      next();
    end
    check("stall_first_stb", 64'(s_cyc_first), 64'd1);
`ifdef WB_ARB_TIMEOUT_EN
    check("to_err_count", 64'(e_count), 64'd1);
    check("to_err_delay", 64'(e_cyc - s_cyc_first), 64'd17);
    check("to_err_stb_low", 64'(e_stb), 64'h0);
    check("to_err_owner", 64'(e_val), 64'h2);
`else
    check("stall_no_err", 64'(e_count), 64'd0);
`endif
    check("stall_gnt_held", 64'(gnt_o), 64'h2);

    // Reset while m1 owns the bus
    rst = 1'b1;
    next(); rst = 1'b0;
    mid();
    check("midrst_gnt", 64'(gnt_o), 64'h0);
    check("midrst_s_cyc", 64'(s_cyc_o), 64'h0);
    check("midrst_err", 64'(m_err_o), 64'h0);
    next(); m_cyc_i = '0; m_stb_i = '0;
    next(); next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
